// File: rtl/uart_rx_framer_pkg.sv
// Shared UART definitions: framer state encoding and parameter legality check,
// kept here so a future transmitter can reuse them.
package uart_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic bit uart_params_ok(input int unsigned data_bits,
                                        input int unsigned parity_en,
                                        input int unsigned parity_odd,
                                        input int unsigned stop_bits);
    return (data_bits >= 5) && (data_bits <= 8) &&
           (parity_en <= 1) && (parity_odd <= 1) &&
           (stop_bits >= 1) && (stop_bits <= 2);
  endfunction

endpackage

// File: rtl/uart_rx_framer_edge.sv
// Brings rx_clk into the sample_clk domain and emits one bit_tick pulse per rising edge.
module rx_clk_edge_detect (
  input  logic sample_clk,
  input  logic rst,
  input  logic rx_clk_i,
  output logic bit_tick_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge sample_clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign bit_tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start detection, LSB-first data shift, optional parity,
// stop-bit check and a valid/ready holding register for the completed character.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sample_clk,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 data_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CW = $clog2(DATA_BITS);
  localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  if (!uart_params_ok(DATA_BITS, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_bad_params
    $error("uart_rx_framer: illegal parameter combination");
  end

  logic bit_tick;

  rx_clk_edge_detect u_edge (
    .sample_clk (sample_clk),
    .rst        (rst),
    .rx_clk_i   (rx_clk),
    .bit_tick_o (bit_tick)
  );

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_out_q, fe_out_d;
  logic                 pe_out_q, pe_out_d;
  logic                 ovr_q, ovr_d;
  logic                 complete;
  logic                 load;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    complete   = 1'b0;

    if (bit_tick) begin
      case (state_q)
        ST_ARM: if (data_bit) state_d = ST_IDLE;
        ST_IDLE: begin
          if (!data_bit) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
            par_d      = 1'b0;
            ferr_d     = 1'b0;
            perr_d     = 1'b0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_bit, shreg_q[DATA_BITS-1:1]};
          par_d     = par_q ^ data_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(DATA_BITS - 1))
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          perr_d  = par_q ^ data_bit ^ 1'(PARITY_ODD);
          state_d = ST_STOP;
        end
        ST_STOP: begin
          ferr_d     = ferr_q | ~data_bit;
          stop_cnt_d = stop_cnt_q + 1'b1;
          if (stop_cnt_q == SW'(STOP_BITS - 1)) begin
            complete = 1'b1;
            // A low final stop bit means break or slip: re-arm before trusting a start.
            state_d  = data_bit ? ST_IDLE : ST_ARM;
          end
        end
        default: state_d = ST_ARM;
      endcase
    end
  end

  // A completion coinciding with an accepting handshake replaces the character in place.
  always_comb begin
    load     = complete & (~valid_q | rx_ready);
    valid_d  = load | (valid_q & ~rx_ready);
    data_d   = load ? shreg_d : data_q;
    fe_out_d = load ? ferr_d  : fe_out_q;
    pe_out_d = load ? perr_d  : pe_out_q;
    ovr_d    = complete & valid_q & ~rx_ready;
  end

  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q    <= ST_ARM;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_out_q   <= 1'b0;
      pe_out_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_out_q   <= fe_out_d;
      pe_out_q   <= pe_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_frame_err  = fe_out_q;
  assign rx_parity_err = pe_out_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: instance 0 is 8N1, instance 1 is 8E1, instance 2 is 8N2.
module tb_uart_rx_framer;

  logic       sample_clk = 1'b0;
  logic       rx_clk     = 1'b0;
  logic       rst        = 1'b1;
  logic       data_bit   [3];
  logic       rx_ready   [3];
  logic [7:0] rx_data    [3];
  logic       rx_valid   [3];
  logic       rx_ferr    [3];
  logic       rx_perr    [3];
  logic       rx_ovr     [3];
  logic       rx_busy    [3];

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;

  always #5  sample_clk = ~sample_clk;
  always #80 rx_clk     = ~rx_clk;

  uart_rx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .sample_clk(sample_clk), .rst(rst), .rx_clk(rx_clk), .data_bit(data_bit[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .rx_frame_err(rx_ferr[0]), .rx_parity_err(rx_perr[0]), .rx_overrun(rx_ovr[0]),
    .rx_busy(rx_busy[0]));

  uart_rx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .sample_clk(sample_clk), .rst(rst), .rx_clk(rx_clk), .data_bit(data_bit[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .rx_frame_err(rx_ferr[1]), .rx_parity_err(rx_perr[1]), .rx_overrun(rx_ovr[1]),
    .rx_busy(rx_busy[1]));

  uart_rx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .sample_clk(sample_clk), .rst(rst), .rx_clk(rx_clk), .data_bit(data_bit[2]),
    .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .rx_frame_err(rx_ferr[2]), .rx_parity_err(rx_perr[2]), .rx_overrun(rx_ovr[2]),
    .rx_busy(rx_busy[2]));

  always @(posedge sample_clk) if (rx_ovr[0]) ovr_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input int u, input logic b);
    @(posedge rx_clk);
    data_bit[u] = b;
  endtask

  // Start bit, 8 data bits LSB-first, optional parity, then nstop stop bits.
  task automatic send_frame(input int u, input logic [7:0] d, input bit has_par,
                            input logic par_bit, input int nstop, input logic [1:0] stops);
    logic [7:0] dv;
    logic [1:0] sv;
    dv = d;
    sv = stops;
    drive_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(u, dv[i]);
    if (has_par) drive_bit(u, par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(u, sv[s]);
  endtask

  // Called right after the last stop bit is driven: valid rises 25 ns later.
  task automatic expect_char(input int u, input logic [7:0] d, input logic fe,
                             input logic pe, input bit accept);
    #20;
    check_eq("valid_before_tick", 32'(rx_valid[u]), 32'd0);
    #10;
    check_eq("valid_after_tick", 32'(rx_valid[u]), 32'd1);
    check_eq("rx_data", 32'(rx_data[u]), 32'(d));
    check_eq("frame_err", 32'(rx_ferr[u]), 32'(fe));
    check_eq("parity_err", 32'(rx_perr[u]), 32'(pe));
    if (accept) begin
      @(negedge sample_clk);
      rx_ready[u] = 1'b1;
      @(negedge sample_clk);
      rx_ready[u] = 1'b0;
      check_eq("valid_cleared", 32'(rx_valid[u]), 32'd0);
    end
  endtask

  task automatic accept_now(input int u);
    @(negedge sample_clk);
    rx_ready[u] = 1'b1;
    @(negedge sample_clk);
    rx_ready[u] = 1'b0;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      data_bit[i] = 1'b1;
      rx_ready[i] = 1'b0;
    end
    #30;
    check_eq("rst_valid", 32'(rx_valid[0]), 32'd0);
    check_eq("rst_data", 32'(rx_data[0]), 32'd0);
    check_eq("rst_ferr", 32'(rx_ferr[0]), 32'd0);
    check_eq("rst_perr", 32'(rx_perr[0]), 32'd0);
    check_eq("rst_ovr", 32'(rx_ovr[0]), 32'd0);
    check_eq("rst_busy", 32'(rx_busy[0]), 32'd0);
    @(negedge sample_clk);
    rst = 1'b0;
    repeat (2) @(posedge rx_clk);

    // 1: clean 8N1 character
    send_frame(0, 8'h55, 0, 1'b0, 1, 2'b01);
    expect_char(0, 8'h55, 1'b0, 1'b0, 1);
    check_eq("busy_after_stop", 32'(rx_busy[0]), 32'd0);

    // 2: framing error, line held low must not start a frame, then recovery
    send_frame(0, 8'hA3, 0, 1'b0, 1, 2'b00);
    expect_char(0, 8'hA3, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      drive_bit(0, 1'b0);
      #30;
      check_eq("arm_busy", 32'(rx_busy[0]), 32'd0);
      check_eq("arm_valid", 32'(rx_valid[0]), 32'd0);
    end
    drive_bit(0, 1'b1);
    send_frame(0, 8'h3C, 0, 1'b0, 1, 2'b01);
    expect_char(0, 8'h3C, 1'b0, 1'b0, 1);

    // 3: even parity on 0x07 (three ones, so parity bit must be 1)
    send_frame(1, 8'h07, 1, 1'b0, 1, 2'b01);
    expect_char(1, 8'h07, 1'b0, 1'b1, 1);
    send_frame(1, 8'h07, 1, 1'b1, 1, 2'b01);
    expect_char(1, 8'h07, 1'b0, 1'b0, 1);

    // 4: overrun keeps the old character; completion with accept is not an overrun
    send_frame(0, 8'h11, 0, 1'b0, 1, 2'b01);
    expect_char(0, 8'h11, 1'b0, 1'b0, 0);
    send_frame(0, 8'h22, 0, 1'b0, 1, 2'b01);
    #30;
    check_eq("ovr_valid", 32'(rx_valid[0]), 32'd1);
    check_eq("ovr_data_kept", 32'(rx_data[0]), 32'h11);
    check_eq("ovr_pulse", 32'(rx_ovr[0]), 32'd1);
    #10;
    check_eq("ovr_pulse_end", 32'(rx_ovr[0]), 32'd0);
    check_eq("ovr_count", 32'(ovr_cnt), 32'd1);
    accept_now(0);
    send_frame(0, 8'h11, 0, 1'b0, 1, 2'b01);
    expect_char(0, 8'h11, 1'b0, 1'b0, 0);
    send_frame(0, 8'h22, 0, 1'b0, 1, 2'b01);
    #20;
    rx_ready[0] = 1'b1;
    #10;
    rx_ready[0] = 1'b0;
    check_eq("swap_valid", 32'(rx_valid[0]), 32'd1);
    check_eq("swap_data", 32'(rx_data[0]), 32'h22);
    check_eq("swap_no_ovr", 32'(rx_ovr[0]), 32'd0);
    #10;
    check_eq("swap_ovr_count", 32'(ovr_cnt), 32'd1);
    accept_now(0);

    // 5: reset mid-frame with the line low
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    #30;
    check_eq("midframe_busy", 32'(rx_busy[0]), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge sample_clk);
    rst = 1'b0;
    check_eq("post_rst_busy", 32'(rx_busy[0]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive_bit(0, 1'b0);
      #30;
      check_eq("low_after_rst_busy", 32'(rx_busy[0]), 32'd0);
      check_eq("low_after_rst_valid", 32'(rx_valid[0]), 32'd0);
    end
    drive_bit(0, 1'b1);
    send_frame(0, 8'h81, 0, 1'b0, 1, 2'b01);
    expect_char(0, 8'h81, 1'b0, 1'b0, 1);

    // 6: two stop bits, second one low, then back-to-back frames
    send_frame(2, 8'h5A, 0, 1'b0, 2, 2'b01);
    expect_char(2, 8'h5A, 1'b1, 1'b0, 1);
    drive_bit(2, 1'b1);
    send_frame(2, 8'hC3, 0, 1'b0, 2, 2'b11);
    expect_char(2, 8'hC3, 1'b0, 1'b0, 1);
    send_frame(2, 8'h0F, 0, 1'b0, 2, 2'b11);
    expect_char(2, 8'h0F, 1'b0, 1'b0, 1);
    send_frame(2, 8'h96, 0, 1'b0, 2, 2'b11);
    expect_char(2, 8'h96, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
